// File: rtl/cla_pkg.sv
// Shared parameters, stage-depth helper and stage payload layout for the
// pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_DEF_WIDTH = 16;
  localparam int CLA_DEF_BLOCK = 4;

  function automatic int cla_nstage(input int width, input int block);
    if (block < 1) return 1;
    return width / block;
  endfunction

  // Payload carried by each stage register at the default width.
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic                     ovf;
    logic [CLA_DEF_WIDTH-1:0] sum;
    logic [CLA_DEF_WIDTH-1:0] a;
    logic [CLA_DEF_WIDTH-1:0] b;
  } cla_stage_t;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus of the pipelined adder. Handshake: a beat moves on a
// rising edge where valid and ready are both 1; valid holds its payload until then.
interface cla_pipe_adder_if
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_group.sv
// One BLOCK-bit carry-lookahead group: every internal carry is a flat
// sum of generate/propagate products, so there is no ripple inside the group.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = ci.p[0..i-1] | OR_j g[j].p[j+1..i-1]
  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    for (int i = 0; i <= BLOCK; i++) begin
      term = ci;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
  end

  assign s     = p ^ c[BLOCK-1:0];
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one BLOCK-bit group per stage, group carry
// registered between stages, single global advance enable for backpressure.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEF_WIDTH,
  parameter int BLOCK = CLA_DEF_BLOCK
) (
  input logic                 clk,
  input logic                 rst_n,
  cla_pipe_adder_if.slave     bus
);
  localparam int NSTAGE = cla_nstage(WIDTH, BLOCK);

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // Same layout as cla_stage_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t stage_src [NSTAGE];
  stage_t stage_d   [NSTAGE];
  stage_t stage_q   [NSTAGE];

  logic [WIDTH-1:0]  grp_a;
  logic [WIDTH-1:0]  grp_b;
  logic [WIDTH-1:0]  grp_s;
  logic [NSTAGE-1:0] grp_ci;
  logic [NSTAGE-1:0] grp_co;
  logic [NSTAGE-1:0] grp_cmsb;
  logic              adv;

  assign adv          = !stage_q[NSTAGE-1].valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage k consumes the input bus (k=0) or the register of stage k-1.
  always_comb begin
    stage_src[0]       = '0;
    stage_src[0].valid = bus.in_valid;
    stage_src[0].carry = bus.Cin;
    stage_src[0].a     = bus.A;
    stage_src[0].b     = bus.B;
    for (int k = 1; k < NSTAGE; k++) stage_src[k] = stage_q[k-1];
    grp_a  = '0;
    grp_b  = '0;
    grp_ci = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      grp_a[k*BLOCK +: BLOCK] = stage_src[k].a[k*BLOCK +: BLOCK];
      grp_b[k*BLOCK +: BLOCK] = stage_src[k].b[k*BLOCK +: BLOCK];
      grp_ci[k]               = stage_src[k].carry;
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_group
    cla_group #(.BLOCK(BLOCK)) u_group (
      .a     (grp_a[k*BLOCK +: BLOCK]),
      .b     (grp_b[k*BLOCK +: BLOCK]),
      .ci    (grp_ci[k]),
      .s     (grp_s[k*BLOCK +: BLOCK]),
      .co    (grp_co[k]),
      .c_msb (grp_cmsb[k])
    );
  end

  // Only the final stage's ovf reaches the output; it uses the group MSB carry.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      stage_d[k]                         = stage_src[k];
      stage_d[k].sum[k*BLOCK +: BLOCK]   = grp_s[k*BLOCK +: BLOCK];
      stage_d[k].carry                   = grp_co[k];
      stage_d[k].ovf                     = grp_cmsb[k] ^ grp_co[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) stage_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSTAGE; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign bus.out_valid = stage_q[NSTAGE-1].valid;
  assign bus.sum       = stage_q[NSTAGE-1].sum;
  assign bus.cout      = stage_q[NSTAGE-1].carry;
  assign bus.ovf       = stage_q[NSTAGE-1].ovf;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder at 16/4, 8/8 and 32/4 against an arithmetic
// reference model, with streaming, backpressure, bubbles and mid-stream reset.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done16 = 0;
  int   n_done32 = 0;

  logic [65:0] exp16_q[$];
  logic [65:0] exp32_q[$];
  logic [65:0] e16;
  logic [65:0] e32;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) bus16();
  cla_pipe_adder_if #(.WIDTH(8))  bus8();
  cla_pipe_adder_if #(.WIDTH(32)) bus32();

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  cla_pipe_adder #(.WIDTH(8),  .BLOCK(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  cla_pipe_adder #(.WIDTH(32), .BLOCK(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, 64-bit zero-extended sum} from plain integer arithmetic.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin);
    logic [64:0] full;
    logic [63:0] mask;
    logic        co;
    logic        ov;
    mask = (64'd1 << w) - 64'd1;
    full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return {ov, co, full[63:0] & mask};
  endfunction

  function automatic logic [65:0] result_of(input int w);
    case (w)
      8:       return {bus8.ovf,  bus8.cout,  56'd0, bus8.sum};
      32:      return {bus32.ovf, bus32.cout, 32'd0, bus32.sum};
      default: return {bus16.ovf, bus16.cout, 48'd0, bus16.sum};
    endcase
  endfunction

  function automatic logic ready_of(input int w);
    case (w)
      8:       return bus8.in_ready;
      32:      return bus32.in_ready;
      default: return bus16.in_ready;
    endcase
  endfunction

  function automatic logic valid_of(input int w);
    case (w)
      8:       return bus8.out_valid;
      32:      return bus32.out_valid;
      default: return bus16.out_valid;
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic cin);
    case (w)
      8:       begin bus8.in_valid  = v; bus8.A  = a[7:0];  bus8.B  = b[7:0];  bus8.Cin  = cin; end
      32:      begin bus32.in_valid = v; bus32.A = a[31:0]; bus32.B = b[31:0]; bus32.Cin = cin; end
      default: begin bus16.in_valid = v; bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.Cin = cin; end
    endcase
  endtask

  // Presents one operation and returns 1 ns after the edge that accepted it.
  task automatic send_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic cin);
    int guard;
    guard = 0;
    drive(w, 1'b1, a, b, cin);
    @(negedge clk);
    while (!ready_of(w) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq($sformatf("w%0d_send_ready", w), {65'd0, ready_of(w)}, 66'd1);
    if (w == 16) exp16_q.push_back(ref_add(16, a, b, cin));
    if (w == 32) exp32_q.push_back(ref_add(32, a, b, cin));
    @(posedge clk); #1;
    drive(w, 1'b0, a, b, cin);
  endtask

  task automatic wait_valid(input int w, output int lat);
    lat = 1;
    while (!valid_of(w) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Isolated operation: latency, result and a single-cycle out_valid pulse.
  task automatic run_one(input int w, input int exp_lat, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic [65:0] exp_res);
    int lat;
    send_op(w, a, b, cin);
    wait_valid(w, lat);
    check_eq($sformatf("w%0d_latency", w), 66'(lat), 66'(exp_lat));
    check_eq($sformatf("w%0d_one_result", w), result_of(w), exp_res);
    @(posedge clk); #1;
    check_eq($sformatf("w%0d_valid_one_cycle", w), {65'd0, valid_of(w)}, 66'd0);
  endtask

  task automatic drain(input int w);
    int guard;
    guard = 0;
    while (((w == 16) ? exp16_q.size() : exp32_q.size()) != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq($sformatf("w%0d_drained", w), 66'((w == 16) ? exp16_q.size() : exp32_q.size()), 66'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      check_eq("w16_result_expected", {65'd0, exp16_q.size() != 0}, 66'd1);
      if (exp16_q.size() != 0) begin
        e16 = exp16_q.pop_front();
        check_eq("w16_stream_result", result_of(16), e16);
        n_done16++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus32.out_valid && bus32.out_ready) begin
      check_eq("w32_result_expected", {65'd0, exp32_q.size() != 0}, 66'd1);
      if (exp32_q.size() != 0) begin
        e32 = exp32_q.pop_front();
        check_eq("w32_stream_result", result_of(32), e32);
        n_done32++;
      end
    end
  end

  initial begin : main
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] mask;
    int          base;

    drive(16, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(8,  1'b0, 64'd0, 64'd0, 1'b0);
    drive(32, 1'b0, 64'd0, 64'd0, 1'b0);
    bus16.out_ready = 1'b1;
    bus8.out_ready  = 1'b1;
    bus32.out_ready = 1'b1;

    // Reset behaviour
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid16", {65'd0, bus16.out_valid}, 66'd0);
    check_eq("rst_result16", result_of(16), 66'd0);
    check_eq("rst_in_ready16", {65'd0, bus16.in_ready}, 66'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready16", {65'd0, bus16.in_ready}, 66'd1);
    check_eq("rst_out_valid8", {65'd0, bus8.out_valid}, 66'd0);
    check_eq("rst_result32", result_of(32), 66'd0);

    // Directed vectors at 16/4
    run_one(16, 4, 64'h0003, 64'h000B, 1'b1, {2'b00, 64'h000F});
    run_one(16, 4, 64'hFFFF, 64'h0001, 1'b0, {2'b01, 64'h0000});
    run_one(16, 4, 64'h7FFF, 64'h0001, 1'b0, {2'b10, 64'h8000});
    run_one(16, 4, 64'h8000, 64'h8000, 1'b0, {2'b11, 64'h0000});

    // Streaming with a 3-cycle output stall
    base = n_done16;
    fork
      begin
        for (int i = 0; i < 8; i++) send_op(16, 64'($urandom), 64'($urandom), 1'($urandom_range(1)));
      end
      begin : stall
        logic [65:0] snap;
        repeat (5) @(posedge clk);
        #1;
        check_eq("stall_out_valid_before", {65'd0, bus16.out_valid}, 66'd1);
        bus16.out_ready = 1'b0;
        snap = result_of(16);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("stall_in_ready", {65'd0, bus16.in_ready}, 66'd0);
          check_eq("stall_out_valid", {65'd0, bus16.out_valid}, 66'd1);
          check_eq("stall_result_stable", result_of(16), snap);
          @(posedge clk); #1;
        end
        bus16.out_ready = 1'b1;
      end
    join
    drain(16);
    check_eq("stream_count", 66'(n_done16 - base), 66'd8);

    // Bubbles: alternate in_valid, out_valid must alternate 4 cycles later
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_op(16, 64'($urandom), 64'($urandom), 1'($urandom_range(1)));
          @(posedge clk); #1;
        end
      end
      begin
        repeat (4) @(posedge clk);
        for (int i = 0; i < 11; i++) begin
          @(negedge clk);
          check_eq("bubble_out_valid", {65'd0, bus16.out_valid}, {65'd0, (i % 2) == 0});
        end
      end
    join
    drain(16);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) send_op(16, 64'($urandom), 64'($urandom), 1'($urandom_range(1)));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp16_q.delete();
    check_eq("midrst_out_valid", {65'd0, bus16.out_valid}, 66'd0);
    check_eq("midrst_result", result_of(16), 66'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("midrst_no_stale", {65'd0, bus16.out_valid}, 66'd0);
    end
    @(posedge clk); #1;
    ra = 64'($urandom_range(16'hFFFF));
    rb = 64'($urandom_range(16'hFFFF));
    run_one(16, 4, ra, rb, 1'b1, ref_add(16, ra, rb, 1'b1));

    // 8/8: single-stage configuration
    run_one(8, 1, 64'hFF, 64'h01, 1'b0, {2'b01, 64'h00});
    for (int i = 0; i < 4; i++) begin
      ra = 64'($urandom_range(255));
      rb = 64'($urandom_range(255));
      run_one(8, 1, ra, rb, 1'b0, ref_add(8, ra, rb, 1'b0));
    end

    // 32/4: latency and every carry-chain boundary
    ra = 64'($urandom);
    rb = 64'($urandom);
    run_one(32, 8, ra, rb, 1'b0, ref_add(32, ra, rb, 1'b0));
    base = n_done32;
    for (int k = 0; k <= 32; k++) begin
      mask = (64'd1 << k) - 64'd1;
      send_op(32, mask, 64'd1, 1'b0);
      send_op(32, mask, 64'd0, 1'b1);
    end
    send_op(32, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0);
    send_op(32, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0);
    drain(32);
    check_eq("w32_boundary_count", 66'(n_done32 - base), 66'd68);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
